// File: rtl/siso_bist_ctrl_if.sv
// -----------------------------------------------------------------------------
// siso_bist_ctrl_if
// Link between the BIST sequencer and the HDSISO8/LFSR8 datapath.
//   LFSR_BIT : reference bit from LFSR8 (the same bit fed to the SISO chain)
//   D_OUT    : SISO output bit, synchronous to the datapath clock
//   LFSR_EN  : LFSR8 enable
//   DIN_SEL  : SISO input mux select (1 = LFSR_BIT)
//   SHOW_SEL : byte-output mux select (1 = LFSR state)
// master = the sequencer, slave = the datapath side.
// -----------------------------------------------------------------------------
interface siso_bist_ctrl_if;
  logic LFSR_BIT;
  logic D_OUT;
  logic LFSR_EN;
  logic DIN_SEL;
  logic SHOW_SEL;

  modport master (
    input  LFSR_BIT,
    input  D_OUT,
    output LFSR_EN,
    output DIN_SEL,
    output SHOW_SEL
  );

  modport slave (
    output LFSR_BIT,
    output D_OUT,
    input  LFSR_EN,
    input  DIN_SEL,
    input  SHOW_SEL
  );
endinterface

// File: rtl/siso_bist_ctrl.sv
// -----------------------------------------------------------------------------
// siso_bist_ctrl
// Built-in self-test sequencer for the HDSISO8 shift-register datapath.
// Starts the LFSR, steers the SISO input to the LFSR bit, waits out the SISO
// latency (PRIME, DEPTH cycles), then compares D_OUT against a delayed copy of
// the LFSR bit for RUN_LEN cycles (CHECK) and reports pass/fail + error count.
//
// Parameters:
//   DEPTH   : LFSR_BIT -> D_OUT latency in cycles (1..255)
//   RUN_LEN : number of compared cycles (1..255)
//   ERR_W   : width of the saturating error counter
//
// Ports:
//   CLK       in   clock (CLK_OUT domain)
//   RESET     in   asynchronous active-low reset
//   START     in   async pad level; synchronized rising edge launches a test
//   ABORT     in   async pad level; synchronized high forces IDLE
//   link      if   datapath link (LFSR_BIT, D_OUT in; LFSR_EN, DIN_SEL,
//                  SHOW_SEL out)
//   BUSY      out  high in PRIME or CHECK
//   DONE      out  high in DONE
//   PASS      out  DONE and ERR_CNT == 0
//   ERR_CNT   out  saturating mismatch count
//   FIRST_ERR out  CHECK index of the first mismatch (0xFF = none)
//
// Optional feature macro: SISO_BIST_FIRST_ERR_EN
//   defined   : FIRST_ERR is captured in flops
//   undefined : FIRST_ERR is tied to 8'hFF
// -----------------------------------------------------------------------------
module siso_bist_ctrl #(
  parameter int DEPTH   = 16,
  parameter int RUN_LEN = 255,
  parameter int ERR_W   = 8
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 START,
  input  logic                 ABORT,
  siso_bist_ctrl_if.master     link,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 PASS,
  output logic [ERR_W-1:0]     ERR_CNT,
  output logic [7:0]           FIRST_ERR
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRIME = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [7:0]       DEPTH_LAST = 8'(DEPTH - 1);
  localparam logic [7:0]       RUN_LAST   = 8'(RUN_LEN - 1);
  localparam logic [ERR_W-1:0] ERR_MAX    = {ERR_W{1'b1}};

  state_t           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [DEPTH-1:0] ref_q, ref_d;

  logic start_s1_q, start_s2_q, start_prev_q;
  logic abort_s1_q, abort_s2_q;
  logic start_edge;
  logic active;
  logic mismatch;

  // ---------------------------------------------------------------------------
  // Pad synchronizers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      start_s1_q   <= 1'b0;
      start_s2_q   <= 1'b0;
      start_prev_q <= 1'b0;
      abort_s1_q   <= 1'b0;
      abort_s2_q   <= 1'b0;
    end else begin
      start_s1_q   <= START;
      start_s2_q   <= start_s1_q;
      start_prev_q <= start_s2_q;
      abort_s1_q   <= ABORT;
      abort_s2_q   <= abort_s1_q;
    end
  end

  // prev tracks every cycle, so an edge swallowed by ABORT is gone for good.
  assign start_edge = start_s2_q & ~start_prev_q;

  assign active   = (state_q == S_PRIME) || (state_q == S_CHECK);
  assign mismatch = link.D_OUT ^ ref_q[DEPTH-1];

  // ---------------------------------------------------------------------------
  // Reference delay line: one stage per cycle of datapath latency, advanced
  // only while the LFSR runs so it stays aligned with the SISO chain.
  // ---------------------------------------------------------------------------
  generate
    if (DEPTH == 1) begin : g_ref1
      always_comb ref_d = active ? link.LFSR_BIT : ref_q;
    end else begin : g_refn
      always_comb ref_d = active ? {ref_q[DEPTH-2:0], link.LFSR_BIT} : ref_q;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Optional first-error capture
  // ---------------------------------------------------------------------------
`ifdef SISO_BIST_FIRST_ERR_EN
  logic [7:0] first_err_q, first_err_d;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
`ifdef SISO_BIST_FIRST_ERR_EN
    first_err_d = first_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!abort_s2_q && start_edge) begin
          state_d = S_PRIME;
          cnt_d   = 8'd0;
          err_d   = '0;
`ifdef SISO_BIST_FIRST_ERR_EN
          first_err_d = 8'hFF;
`endif
        end
      end
      S_PRIME: begin
        if (abort_s2_q) begin
          state_d = S_IDLE;
        end else if (cnt_q == DEPTH_LAST) begin
          state_d = S_CHECK;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_CHECK: begin
        if (abort_s2_q) begin
          state_d = S_IDLE;
        end else begin
          if (mismatch && (err_q != ERR_MAX)) begin
            err_d = err_q + 1'b1;
          end
`ifdef SISO_BIST_FIRST_ERR_EN
          // Index never reaches 0xFF (RUN_LEN <= 255), so 0xFF means "none yet".
          if (mismatch && (first_err_q == 8'hFF)) begin
            first_err_d = cnt_q;
          end
`endif
          if (cnt_q == RUN_LAST) begin
            state_d = S_DONE;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      S_DONE: begin
        if (abort_s2_q) begin
          state_d = S_IDLE;
        end else if (start_edge) begin
          state_d = S_PRIME;
          cnt_d   = 8'd0;
          err_d   = '0;
`ifdef SISO_BIST_FIRST_ERR_EN
          first_err_d = 8'hFF;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      err_q   <= '0;
      ref_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ref_q   <= ref_d;
    end
  end

`ifdef SISO_BIST_FIRST_ERR_EN
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      first_err_q <= 8'h00;
    end else begin
      first_err_q <= first_err_d;
    end
  end
  assign FIRST_ERR = first_err_q;
`else
  assign FIRST_ERR = 8'hFF;
`endif

  // ---------------------------------------------------------------------------
  // Outputs: decoded from registers only
  // ---------------------------------------------------------------------------
  assign link.LFSR_EN  = active;
  assign link.DIN_SEL  = active;
  assign link.SHOW_SEL = active;
  assign BUSY          = active;
  assign DONE          = (state_q == S_DONE);
  assign PASS          = (state_q == S_DONE) && (err_q == '0);
  assign ERR_CNT       = err_q;

endmodule

// File: tb/tb_siso_bist_ctrl.sv
// -----------------------------------------------------------------------------
// tb_siso_bist_ctrl
// Directed bench: LFSR8 + 16-cycle SISO loopback model with error injection
// at chosen CHECK indices, plus a second instance with ERR_W = 4 fed with an
// always-inverted D_OUT to exercise saturation.
// -----------------------------------------------------------------------------
module tb_siso_bist_ctrl;

  localparam int DEPTH   = 16;
  localparam int RUN_LEN = 255;
  localparam int NONE    = -100;

  logic       clk;
  logic       rst_n;
  logic       start, abort;
  logic       busy, done_o, pass;
  logic [7:0] err_cnt;
  logic [7:0] first_err;

  logic       start2;
  logic       busy2, done2, pass2;
  logic [3:0] err_cnt2;
  logic [7:0] first_err2;

  int tests_run = 0;
  int tests_failed = 0;

  siso_bist_ctrl_if link ();
  siso_bist_ctrl_if link2 ();

  siso_bist_ctrl #(.DEPTH(DEPTH), .RUN_LEN(RUN_LEN), .ERR_W(8)) dut (
    .CLK(clk), .RESET(rst_n), .START(start), .ABORT(abort), .link(link),
    .BUSY(busy), .DONE(done_o), .PASS(pass), .ERR_CNT(err_cnt),
    .FIRST_ERR(first_err)
  );

  siso_bist_ctrl #(.DEPTH(16), .RUN_LEN(40), .ERR_W(4)) dut_w4 (
    .CLK(clk), .RESET(rst_n), .START(start2), .ABORT(1'b0), .link(link2),
    .BUSY(busy2), .DONE(done2), .PASS(pass2), .ERR_CNT(err_cnt2),
    .FIRST_ERR(first_err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath model for the main instance
  logic [7:0]  lfsr = 8'h01;
  logic [15:0] dl = '0;
  int          en_cnt = 0;
  int          inj0 = NONE, inj1 = NONE, inj2 = NONE;
  int          chk_idx;
  logic        flip;

  always @(posedge clk) begin
    if (link.LFSR_EN) lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    dl     <= {dl[14:0], link.LFSR_BIT};
    en_cnt <= link.LFSR_EN ? en_cnt + 1 : 0;
  end

  assign chk_idx       = en_cnt - DEPTH;
  assign flip          = link.LFSR_EN && ((chk_idx == inj0) || (chk_idx == inj1) || (chk_idx == inj2));
  assign link.LFSR_BIT = lfsr[7];
  assign link.D_OUT    = dl[15] ^ flip;

  // Datapath model for the ERR_W = 4 instance: D_OUT always wrong
  logic [7:0]  lfsr2 = 8'h5A;
  logic [15:0] dl2 = '0;
  always @(posedge clk) begin
    if (link2.LFSR_EN) lfsr2 <= {lfsr2[6:0], lfsr2[7] ^ lfsr2[5] ^ lfsr2[4] ^ lfsr2[3]};
    dl2 <= {dl2[14:0], link2.LFSR_BIT};
  end
  assign link2.LFSR_BIT = lfsr2[7];
  assign link2.D_OUT    = ~dl2[15];

  task automatic chk(input string nm, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] fe(input int i);
`ifdef SISO_BIST_FIRST_ERR_EN
    return i[7:0];
`else
    return (i >= 0) ? 8'hFF : 8'hFF;
`endif
  endfunction

  typedef struct {
    int         i0, i1, i2;
    logic       hold;
    int         exp_err;
    logic       exp_pass;
    logic [7:0] exp_first;
  } vec_t;

  vec_t vecs [6];

  task automatic run_vec(input int v);
    int n, cyc;
    inj0 = vecs[v].i0; inj1 = vecs[v].i1; inj2 = vecs[v].i2;
    start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("launch_latency_en_low", int'(link.LFSR_EN), 0);
    @(negedge clk);
    chk("launch_en_high", int'(link.LFSR_EN), 1);
    chk("entry_err_clear", int'(err_cnt), 0);
    chk("entry_sel", int'({link.DIN_SEL, link.SHOW_SEL, busy, done_o}), 4'b1110);
    if (!vecs[v].hold) start = 1'b0;
    n = 1;
    cyc = 0;
    while (cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (done_o) break;
      if (link.LFSR_EN) n++;
    end
    chk("done_timeout", int'(cyc >= 1000), 0);
    chk("en_cycles", n, DEPTH + RUN_LEN);
    chk("done", int'(done_o), 1);
    chk("busy_off", int'({busy, link.LFSR_EN, link.DIN_SEL, link.SHOW_SEL}), 0);
    chk("err_cnt", int'(err_cnt), vecs[v].exp_err);
    chk("pass", int'(pass), int'(vecs[v].exp_pass));
    chk("first_err", int'(first_err), int'(vecs[v].exp_first));
    $display("[TB] vec %0d: en_cycles=%0d err=%0d pass=%0d first=0x%02h", v, n, err_cnt, pass, first_err);
    if (vecs[v].hold) begin
      logic seen;
      seen = 1'b0;
      repeat (10) begin
        @(negedge clk);
        seen |= busy;
      end
      chk("hold_no_retrigger", int'(seen), 0);
      chk("hold_still_done", int'(done_o), 1);
      start = 1'b0;
      repeat (3) @(negedge clk);
    end
  endtask

  initial begin
    logic seen;
    int   cyc;

    vecs[0] = '{NONE, NONE, NONE, 1'b0, 0, 1'b1, 8'hFF};
    vecs[1] = '{10,   NONE, NONE, 1'b0, 1, 1'b0, fe(10)};
    vecs[2] = '{10,   20,   30,   1'b0, 3, 1'b0, fe(10)};
    vecs[3] = '{NONE, NONE, NONE, 1'b1, 0, 1'b1, 8'hFF};
    vecs[4] = '{0,    254,  NONE, 1'b0, 2, 1'b0, fe(0)};
    vecs[5] = '{254,  NONE, NONE, 1'b0, 1, 1'b0, fe(254)};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; start2 = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", int'({busy, done_o, pass, link.LFSR_EN, link.DIN_SEL, link.SHOW_SEL}), 0);
    chk("reset_err", int'(err_cnt), 0);
`ifdef SISO_BIST_FIRST_ERR_EN
    chk("reset_first_err", int'(first_err), 0);
`else
    chk("reset_first_err", int'(first_err), 255);
`endif
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_no_activity", int'(busy), 0);

    for (int v = 0; v < 6; v++) run_vec(v);

    // ABORT from DONE: error count retained, DONE/PASS drop
    abort = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_done_done", int'(done_o), 0);
    chk("abort_done_pass", int'(pass), 0);
    chk("abort_done_err_kept", int'(err_cnt), 1);
    abort = 1'b0;
    repeat (3) @(negedge clk);
    $display("[TB] abort from DONE: done=%0d err=%0d", done_o, err_cnt);

    // ABORT at PRIME cycle 5
    inj0 = NONE; inj1 = NONE; inj2 = NONE;
    start = 1'b1;
    cyc = 0;
    while (!(link.LFSR_EN && en_cnt == 5) && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("prime5_timeout", int'(cyc >= 50), 0);
    start = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    chk("abort_sync1_busy", int'(busy), 1);
    @(negedge clk);
    chk("abort_sync2_busy", int'(busy), 1);
    @(negedge clk);
    chk("abort_prime_off", int'({busy, link.LFSR_EN, done_o}), 0);
    abort = 1'b0;
    repeat (4) @(negedge clk);
    $display("[TB] abort in PRIME: busy=%0d en=%0d", busy, link.LFSR_EN);

    // START and ABORT together: START edge is discarded
    start = 1'b1; abort = 1'b1;
    seen = 1'b0;
    repeat (8) begin @(negedge clk); seen |= busy; end
    abort = 1'b0;
    repeat (6) begin @(negedge clk); seen |= busy; end
    start = 1'b0;
    repeat (4) begin @(negedge clk); seen |= busy; end
    chk("start_abort_together", int'(seen), 0);
    $display("[TB] start+abort together: busy_seen=%0d", seen);

    // Async reset at CHECK index 100
    inj0 = 50;
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!(link.LFSR_EN && en_cnt == DEPTH + 100) && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    chk("check100_timeout", int'(cyc >= 400), 0);
    chk("pre_reset_err", int'(err_cnt), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", int'({busy, done_o, pass, link.LFSR_EN, link.DIN_SEL, link.SHOW_SEL}), 0);
    chk("async_reset_err", int'(err_cnt), 0);
`ifdef SISO_BIST_FIRST_ERR_EN
    chk("async_reset_first_err", int'(first_err), 0);
`else
    chk("async_reset_first_err", int'(first_err), 255);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    inj0 = NONE;
    seen = 1'b0;
    repeat (20) begin @(negedge clk); seen |= busy | done_o; end
    chk("post_reset_quiet", int'(seen), 0);
    $display("[TB] async reset mid-CHECK: outputs cleared, quiet=%0d", !seen);

    // Saturation with ERR_W = 4
    start2 = 1'b1;
    repeat (3) @(negedge clk);
    start2 = 1'b0;
    cyc = 0;
    while (!done2 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("w4_timeout", int'(cyc >= 200), 0);
    chk("w4_err_saturated", int'(err_cnt2), 15);
    chk("w4_pass", int'(pass2), 0);
    $display("[TB] ERR_W=4 saturation: err=%0d pass=%0d", err_cnt2, pass2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/siso_bist_ctrl.md
Name: siso_bist_ctrl

Overview:
Built-in self-test sequencer for the HDSISO8 shift-register datapath. It starts the LFSR, steers SISO input to the LFSR bit, and waits out the SISO pipeline latency. It then compares D_OUT against an internally delayed copy of the LFSR bit for a fixed run length and reports pass/fail plus an error count. It sits beside LFSR8 in the top level, clocked by CLK_OUT and reset by INT_RESET. It drives the LFSR_EN, DIN_SEL and SHOW_LFSR selects that are currently pin-driven.

Parameters:
DEPTH, 16, cycles from LFSR_BIT at this block's input to the matching bit at D_OUT (includes the SISO input register); legal 1..255
RUN_LEN, 255, number of compared cycles in CHECK; legal 1..255
ERR_W, 8, width of the saturating error counter

Ports:
CLK  in  1  clock (CLK_OUT domain)
RESET  in  1  asynchronous, active-low reset
START  in  1  async level from pad; a synchronized rising edge launches a test
ABORT  in  1  async level from pad; while synchronized high, forces return to IDLE
LFSR_BIT  in  1  reference bit from LFSR8, the same bit fed to SISO
D_OUT  in  1  SISO output bit, synchronous to CLK
LFSR_EN  out  1  LFSR8 enable
DIN_SEL  out  1  SISO input mux select (1 = LFSR_BIT)
SHOW_SEL  out  1  byte-output mux select (1 = LFSR state)
BUSY  out  1  high in PRIME or CHECK
DONE  out  1  high in DONE state
PASS  out  1  DONE and ERR_CNT == 0
ERR_CNT  out  ERR_W  saturating mismatch count
FIRST_ERR  out  8  CHECK index of first mismatch (optional feature)

Behaviour:
- Reset: all outputs 0; state IDLE; counters, synchronizers and the reference delay line cleared to 0.
- Synchronizers: START and ABORT each pass through 2 flops. START edge = sync2 & ~prev.
- Latency: START rises before edge n -> state/outputs change after edge n+2. ABORT has the same latency.
- All outputs are registered or decoded directly from the state register. No combinational path from inputs to outputs.
- States: IDLE, PRIME, CHECK, DONE.
- IDLE: all control outputs 0. START edge -> PRIME; ERR_CNT and FIRST_ERR are cleared on entry.
- PRIME: LFSR_EN = DIN_SEL = SHOW_SEL = BUSY = 1. Lasts exactly DEPTH cycles; no compare. Then -> CHECK.
- CHECK: outputs as in PRIME. Lasts exactly RUN_LEN cycles; index runs 0..RUN_LEN-1.
  - Each cycle compares D_OUT with ref[DEPTH-1]. ref is a DEPTH-bit shift register loaded from LFSR_BIT every cycle LFSR_EN = 1.
  - On mismatch: ERR_CNT += 1, saturating at 2^ERR_W-1.
  - After the last cycle -> DONE.
- DONE: LFSR_EN = DIN_SEL = SHOW_SEL = BUSY = 0; DONE = 1; PASS valid. ERR_CNT and FIRST_ERR are held. START edge -> PRIME (rerun).
- ABORT high (synced) in PRIME, CHECK or DONE -> IDLE next edge. ERR_CNT is retained; DONE and PASS = 0. ABORT in IDLE has no effect.
- START edge and ABORT together: ABORT wins; the START edge is discarded, not queued.
- START held high does not retrigger; a new rising edge is required.
- Counter width is 8 bits (covers DEPTH and RUN_LEN ≤ 255).
- Async RESET in any state -> immediate IDLE and all outputs 0. The delay line is cleared, so no stale reference survives.

Optional Feature:
SISO_BIST_FIRST_ERR_EN
- Defined: FIRST_ERR captures the CHECK index of the first mismatch since PRIME entry. It is cleared to 0xFF on PRIME entry and holds 0xFF if there is no mismatch.
- Undefined: the port exists but is tied to 8'hFF, and no capture flops are synthesized.

Test Plan:
1. Loopback model (D_OUT = LFSR_BIT delayed 16 cycles), defaults. START pulse -> LFSR_EN = 1 two edges later for exactly 271 cycles; then DONE = 1, PASS = 1, ERR_CNT = 0, FIRST_ERR = 0xFF.
2. Same model with one D_OUT bit inverted at CHECK index 10 -> ERR_CNT = 1, PASS = 0, FIRST_ERR = 10 with macro, 0xFF without.
3. D_OUT = ~expected throughout, ERR_W = 4 -> ERR_CNT saturates at 15 (no wrap), PASS = 0.
4. ABORT raised at PRIME cycle 5 -> IDLE two edges later with LFSR_EN = BUSY = DONE = 0. START and ABORT raised on the same edge -> BUSY never asserts.
5. RESET asserted low at CHECK index 100 -> all outputs 0 with no clock edge. On release, no activity until a fresh START edge.
6. From DONE with ERR_CNT = 3, a new START edge -> ERR_CNT = 0 on PRIME entry. START held high afterwards does not relaunch after the next DONE.
